// File: rtl/da_bitslice_feeder.sv
// Input-sample delay line for the distributed-arithmetic FIR datapath.
// Each accepted sample releases DATA_W 64-bit bit-planes, MSB first, as eight 8-bit ROM addresses.
module da_bitslice_feeder #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic [DATA_W-1:0] x_in,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [7:0]        A7,
  output logic [7:0]        A6,
  output logic [7:0]        A5,
  output logic [7:0]        A4,
  output logic [7:0]        A3,
  output logic [7:0]        A2,
  output logic [7:0]        A1,
  output logic [7:0]        A0,
  output logic              plane_valid,
  input  logic              plane_ready,
  output logic              plane_first,
  output logic              plane_last,
  output logic              warm
);

  localparam int unsigned TAPS   = 64;
  localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned WARM_W = $clog2(TAPS + 1);
  localparam logic [CNT_W-1:0]  CNT_TOP  = CNT_W'(DATA_W - 1);
  localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(TAPS);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
  logic [DATA_W-1:0] taps_q [TAPS];
  logic              shift_c;
  logic [TAPS-1:0]   plane_c;

  // State, plane counter and warm counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= CNT_TOP;
      warm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  // Next state and handshake; clear overrides everything, dropping any coincident plane transfer
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    warm_cnt_d  = warm_cnt_q;
    shift_c     = 1'b0;
    x_ready     = 1'b0;
    plane_valid = (state_q == EMIT);
    if (clear) begin
      state_d    = IDLE;
      bit_cnt_d  = CNT_TOP;
      warm_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          x_ready = 1'b1;
          if (x_valid) begin
            shift_c   = 1'b1;
            bit_cnt_d = CNT_TOP;
            state_d   = EMIT;
            if (warm_cnt_q != WARM_MAX) begin
              warm_cnt_d = warm_cnt_q + 1'b1;
            end
          end
        end
        EMIT: begin
          if (plane_ready) begin
            if (bit_cnt_q == '0) begin
              bit_cnt_d = CNT_TOP;
              state_d   = IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q - 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Delay line: tap 0 holds the newest sample
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
    end else if (shift_c) begin
      taps_q[0] <= x_in;
      for (int i = 1; i < TAPS; i++) taps_q[i] <= taps_q[i-1];
    end
  end

  // Bit-plane select: plane bit i is bit bit_cnt of tap i
  always_comb begin
    plane_c = '0;
    for (int i = 0; i < TAPS; i++) plane_c[i] = taps_q[i][bit_cnt_q];
  end

  assign A0 = plane_c[7:0];
  assign A1 = plane_c[15:8];
  assign A2 = plane_c[23:16];
  assign A3 = plane_c[31:24];
  assign A4 = plane_c[39:32];
  assign A5 = plane_c[47:40];
  assign A6 = plane_c[55:48];
  assign A7 = plane_c[63:56];

  assign plane_first = (bit_cnt_q == CNT_TOP);
  assign plane_last  = (bit_cnt_q == '0);
  assign warm        = (warm_cnt_q == WARM_MAX);

endmodule
